axi_wdata_order_ctrl: RTL and testbench

Write-data channel scheduler for the 3-master AXI interconnect slave port. It records the order in which the write-address arbiter accepts AW transfers, as one-hot grant entries in a small FIFO. It grants the W channel to the master at the FIFO head until that master's WLAST beat handshakes. This replaces beat-by-beat W arbitration, so write data always follows AW acceptance order and bursts are never interleaved.

---
 rtl/axi_wdata_order_ctrl.sv | 105 ++++++++++
 tb/tb_axi_wdata_order_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/axi_wdata_order_ctrl.sv
// axi_wdata_order_ctrl
// Write-data channel scheduler for a multi-master AXI slave port. Each accepted
// AW transfer pushes its one-hot grant into a small FIFO. The W channel is
// granted to the master at the FIFO head until that master's WLAST beat
// handshakes. Write data therefore follows AW acceptance order, and bursts are
// never interleaved.
//
// Handshake semantics: a transfer occurs on a rising AXI_CLK edge when VALID
// and READY are both high for the same master. An AW transfer counts only for
// the master selected by AWGRANT. A W transfer counts only for the master
// selected by WGRANT. Only the W beat carrying WLAST changes state. VALID/READY
// from masters that are not selected are ignored.

module axi_wdata_order_ctrl #(
    parameter int NUM   = 3,
    parameter int DEPTH = 4,
    parameter int W_CNT = 3
) (
    input  logic             AXI_CLK,
    input  logic             AXI_RST,
    input  logic [NUM-1:0]   AWGRANT,
    input  logic [NUM-1:0]   AWVALID,
    input  logic [NUM-1:0]   AWREADY,
    input  logic [NUM-1:0]   WVALID,
    input  logic [NUM-1:0]   WREADY,
    input  logic [NUM-1:0]   WLAST,
    output logic [NUM-1:0]   WGRANT,
    output logic             AW_FULL,
    output logic [W_CNT-1:0] OCCUPANCY,
    output logic             OVERFLOW,
    output logic             GRANT_ERR
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [W_CNT-1:0] CNT_FULL = W_CNT'(DEPTH);

    logic [NUM-1:0]   mem [DEPTH];
    logic [PW-1:0]    wp;
    logic [PW-1:0]    rp;
    logic [W_CNT-1:0] cnt;

    logic aw_hs;
    logic w_last_hs;
    logic full;
    logic empty;
    logic push;
    logic pop;
    logic grant_bad;

    // Handshake decode, push/pop qualification and one-hot check of AWGRANT
    always_comb begin
        aw_hs     = |(AWGRANT & AWVALID & AWREADY);
        w_last_hs = |(WGRANT & WVALID & WREADY & WLAST);
        full      = (cnt == CNT_FULL);
        empty     = (cnt == '0);
        pop       = w_last_hs && !empty;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts
        push      = aw_hs && (!full || pop);
        grant_bad = (AWGRANT == '0) || ((AWGRANT & (AWGRANT - 1'b1)) != '0);
    end

    // Grant storage; contents need no reset because cnt qualifies every read
    always_ff @(posedge AXI_CLK) begin
        if (!AXI_RST && push) begin
            mem[wp] <= AWGRANT;
        end
    end

    // Pointers, occupancy count and sticky error flags
    always_ff @(posedge AXI_CLK) begin
        if (AXI_RST) begin
            wp        <= '0;
            rp        <= '0;
            cnt       <= '0;
            OVERFLOW  <= 1'b0;
            GRANT_ERR <= 1'b0;
        end else begin
            if (push) begin
                wp <= wp + 1'b1;
            end
            if (pop) begin
                rp <= rp + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            if (aw_hs && full && !pop) begin
                OVERFLOW <= 1'b1;
            end
            if (push && grant_bad) begin
                GRANT_ERR <= 1'b1;
            end
        end
    end

    // Outputs decoded from registered state only
    always_comb begin
        WGRANT    = empty ? '0 : mem[rp];
        AW_FULL   = full;
        OCCUPANCY = cnt;
    end

endmodule

// File: tb/tb_axi_wdata_order_ctrl.sv
// tb_axi_wdata_order_ctrl
// Directed bench for axi_wdata_order_ctrl. The expected W grant order is held
// in a queue. Entries are pushed when an AW handshake is expected to be
// accepted, and popped when the matching WLAST beat completes.

module tb_axi_wdata_order_ctrl;

    logic       AXI_CLK = 1'b0;
    logic       AXI_RST;
    logic [2:0] AWGRANT, AWVALID, AWREADY;
    logic [2:0] WVALID, WREADY, WLAST;
    logic [2:0] WGRANT;
    logic       AW_FULL;
    logic [2:0] OCCUPANCY;
    logic       OVERFLOW;
    logic       GRANT_ERR;

    logic [2:0] exp_q[$];
    int         checks = 0;
    int         errors = 0;

    axi_wdata_order_ctrl #(.NUM(3), .DEPTH(4), .W_CNT(3)) dut (
        .AXI_CLK   (AXI_CLK),
        .AXI_RST   (AXI_RST),
        .AWGRANT   (AWGRANT),
        .AWVALID   (AWVALID),
        .AWREADY   (AWREADY),
        .WVALID    (WVALID),
        .WREADY    (WREADY),
        .WLAST     (WLAST),
        .WGRANT    (WGRANT),
        .AW_FULL   (AW_FULL),
        .OCCUPANCY (OCCUPANCY),
        .OVERFLOW  (OVERFLOW),
        .GRANT_ERR (GRANT_ERR)
    );

    // clock
    always #5 AXI_CLK = ~AXI_CLK;

    // advance one cycle; inputs and samples both sit 1 time unit after the edge
    task automatic tick();
        @(posedge AXI_CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        AWGRANT = '0; AWVALID = '0; AWREADY = '0;
        WVALID  = '0; WREADY  = '0; WLAST   = '0;
    endtask

    // one AW handshake by the granted master(s); accepted entries go to the scoreboard
    task automatic aw_push(input logic [2:0] g, input bit accepted);
        AWGRANT = g; AWVALID = g; AWREADY = g;
        tick();
        AWGRANT = '0; AWVALID = '0; AWREADY = '0;
        if (accepted) exp_q.push_back(g);
    endtask

    // drive a burst on the expected head master, checking grant stability
    task automatic w_burst(input int beats);
        logic [2:0] h;
        h = exp_q[0];
        check("head_grant", {5'd0, WGRANT}, {5'd0, h});
        for (int i = 0; i < beats; i++) begin
            WVALID = h;
            WREADY = h;
            WLAST  = (i == beats - 1) ? h : 3'b000;
            tick();
            if (i != beats - 1) check("mid_burst_grant", {5'd0, WGRANT}, {5'd0, h});
        end
        WVALID = '0; WREADY = '0; WLAST = '0;
        void'(exp_q.pop_front());
        check("next_grant", {5'd0, WGRANT}, {5'd0, (exp_q.size() != 0) ? exp_q[0] : 3'b000});
        check("occ_after_burst", {5'd0, OCCUPANCY}, 8'(exp_q.size()));
    endtask

    task automatic do_reset();
        AXI_RST = 1'b1;
        tick();
        AXI_RST = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        idle_inputs();
        AXI_RST = 1'b1;
        tick();
        tick();
        AXI_RST = 1'b0;

        // reset state
        check("rst_wgrant", {5'd0, WGRANT}, 8'd0);
        check("rst_full", {7'd0, AW_FULL}, 8'd0);
        check("rst_occ", {5'd0, OCCUPANCY}, 8'd0);
        check("rst_ovf", {7'd0, OVERFLOW}, 8'd0);
        check("rst_gerr", {7'd0, GRANT_ERR}, 8'd0);

        // single burst: grant next cycle, held for 3 beats, released on the 4th
        aw_push(3'b010, 1'b1);
        check("t1_occ", {5'd0, OCCUPANCY}, 8'd1);
        check("t1_grant", {5'd0, WGRANT}, 8'b010);
        w_burst(4);

        // ordering follows AW acceptance; beats from non-head masters are ignored
        aw_push(3'b100, 1'b1);
        aw_push(3'b001, 1'b1);
        aw_push(3'b010, 1'b1);
        WVALID = 3'b011; WREADY = 3'b011; WLAST = 3'b011;
        tick();
        WVALID = '0; WREADY = '0; WLAST = '0;
        check("t2_nonhead_grant", {5'd0, WGRANT}, 8'b100);
        check("t2_nonhead_occ", {5'd0, OCCUPANCY}, 8'd3);
        w_burst(2);
        w_burst(1);
        w_burst(3);

        // fill, then overflow drops the fifth entry
        aw_push(3'b001, 1'b1);
        aw_push(3'b010, 1'b1);
        aw_push(3'b100, 1'b1);
        aw_push(3'b001, 1'b1);
        check("t3_full", {7'd0, AW_FULL}, 8'd1);
        check("t3_occ", {5'd0, OCCUPANCY}, 8'd4);
        check("t3_ovf_before", {7'd0, OVERFLOW}, 8'd0);
        aw_push(3'b100, 1'b0);
        check("t3_ovf", {7'd0, OVERFLOW}, 8'd1);
        check("t3_occ_after_ovf", {5'd0, OCCUPANCY}, 8'd4);
        w_burst(1);
        w_burst(1);
        w_burst(1);
        w_burst(1);
        check("t3_ovf_sticky", {7'd0, OVERFLOW}, 8'd1);
        check("t3_empty_full", {7'd0, AW_FULL}, 8'd0);
        do_reset();
        check("t3_ovf_cleared", {7'd0, OVERFLOW}, 8'd0);

        // simultaneous push and pop while full
        aw_push(3'b010, 1'b1);
        aw_push(3'b100, 1'b1);
        aw_push(3'b010, 1'b1);
        aw_push(3'b100, 1'b1);
        check("t4_full", {7'd0, AW_FULL}, 8'd1);
        AWGRANT = 3'b001; AWVALID = 3'b001; AWREADY = 3'b001;
        WVALID = exp_q[0]; WREADY = exp_q[0]; WLAST = exp_q[0];
        tick();
        idle_inputs();
        void'(exp_q.pop_front());
        exp_q.push_back(3'b001);
        check("t4_occ", {5'd0, OCCUPANCY}, 8'd4);
        check("t4_ovf", {7'd0, OVERFLOW}, 8'd0);
        check("t4_full_kept", {7'd0, AW_FULL}, 8'd1);
        check("t4_grant", {5'd0, WGRANT}, 8'b100);
        w_burst(2);
        w_burst(1);
        w_burst(2);
        check("t4_last_is_m0", {5'd0, WGRANT}, 8'b001);
        w_burst(1);

        // reset mid-burst, with an AW handshake in the reset cycle
        aw_push(3'b100, 1'b1);
        aw_push(3'b001, 1'b1);
        WVALID = 3'b100; WREADY = 3'b100; WLAST = 3'b000;
        tick();
        check("t5_midburst_grant", {5'd0, WGRANT}, 8'b100);
        AWGRANT = 3'b010; AWVALID = 3'b010; AWREADY = 3'b010;
        do_reset();
        idle_inputs();
        check("t5_wgrant", {5'd0, WGRANT}, 8'd0);
        check("t5_occ", {5'd0, OCCUPANCY}, 8'd0);
        check("t5_full", {7'd0, AW_FULL}, 8'd0);
        aw_push(3'b010, 1'b1);
        check("t5_new_grant", {5'd0, WGRANT}, 8'b010);
        w_burst(1);

        // non-one-hot AW grant is stored as given and flagged
        aw_push(3'b001, 1'b1);
        check("t6_gerr_clean", {7'd0, GRANT_ERR}, 8'd0);
        aw_push(3'b011, 1'b1);
        check("t6_gerr", {7'd0, GRANT_ERR}, 8'd1);
        w_burst(2);
        check("t6_bad_grant_head", {5'd0, WGRANT}, 8'b011);
        w_burst(1);
        check("t6_gerr_sticky", {7'd0, GRANT_ERR}, 8'd1);
        do_reset();
        check("t6_gerr_cleared", {7'd0, GRANT_ERR}, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
